// File: rtl/loop_ctrl_nested_walker_drv_if.sv
// Handshake bundle between the instruction decoder and the nested-loop controller.
// The decoder side is the master; the controller is the slave.
interface loop_ctrl_nested_walker_drv_if #(
    parameter int LOOP_ID_W   = 5,
    parameter int LOOP_ITER_W = 16
);
    logic                   cfg_loop_iter_v;
    logic [LOOP_ITER_W-1:0] cfg_loop_iter;
    logic                   start;
    logic                   stall;
    logic                   busy;
    logic [LOOP_ID_W-1:0]   loop_index;
    logic                   loop_index_valid;
    logic                   loop_init;
    logic                   loop_enter;
    logic                   loop_exit;
    logic                   loop_ctrl_done;

    modport master (
        output cfg_loop_iter_v, cfg_loop_iter, start, stall,
        input  busy, loop_index, loop_index_valid, loop_init, loop_enter, loop_exit, loop_ctrl_done
    );

    modport slave (
        input  cfg_loop_iter_v, cfg_loop_iter, start, stall,
        output busy, loop_index, loop_index_valid, loop_init, loop_enter, loop_exit, loop_ctrl_done
    );
endinterface

// File: rtl/loop_ctrl_nested_walker_drv.sv
// Nested-loop controller: sequences a configured loop nest and emits init/enter/step/exit/done
// events with the loop level, so stride walkers can follow it in lockstep.
module loop_ctrl_nested_walker_drv #(
    parameter int LOOP_ID_W   = 5,
    parameter int LOOP_ITER_W = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    loop_ctrl_nested_walker_drv_if.slave  bus
);
    localparam int MAX_LOOPS = 2 ** LOOP_ID_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ENTER,
        S_INNER,
        S_STEP,
        S_EXIT,
        S_DONE
    } state_t;

    state_t                 state;
    logic [LOOP_ID_W:0]     num_loops;
    logic [LOOP_ID_W:0]     num_loops_nxt;
    logic                   cfg_accept;
    logic [LOOP_ID_W-1:0]   last;
    logic [LOOP_ID_W-1:0]   level_up;
    logic [LOOP_ITER_W-1:0] iter_buf [MAX_LOOPS];
    logic [LOOP_ITER_W-1:0] cnt      [MAX_LOOPS];

    // A config write in the same cycle as start must be visible to that run, hence num_loops_nxt.
    always_comb begin
        cfg_accept    = bus.cfg_loop_iter_v && !num_loops[LOOP_ID_W];
        num_loops_nxt = num_loops + (LOOP_ID_W+1)'(cfg_accept);
        last          = num_loops[LOOP_ID_W-1:0] - LOOP_ID_W'(1);
        level_up      = bus.loop_index - LOOP_ID_W'(1);
    end

    // Each state's event flag is registered on entry, so the flags line up with state and busy.
    // A stall simply holds everything while the per-cycle flag defaults clear the event outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= S_IDLE;
            num_loops            <= '0;
            bus.busy             <= 1'b0;
            bus.loop_index       <= '0;
            bus.loop_index_valid <= 1'b0;
            bus.loop_init        <= 1'b0;
            bus.loop_enter       <= 1'b0;
            bus.loop_exit        <= 1'b0;
            bus.loop_ctrl_done   <= 1'b0;
            for (int i = 0; i < MAX_LOOPS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            bus.loop_index_valid <= 1'b0;
            bus.loop_init        <= 1'b0;
            bus.loop_enter       <= 1'b0;
            bus.loop_exit        <= 1'b0;
            bus.loop_ctrl_done   <= 1'b0;

            if (state == S_IDLE) begin
                if (cfg_accept) begin
                    iter_buf[num_loops[LOOP_ID_W-1:0]] <= bus.cfg_loop_iter;
                end
                num_loops <= num_loops_nxt;
                if (bus.start) begin
                    if (num_loops_nxt == '0) begin
                        bus.loop_ctrl_done <= 1'b1;
                    end else begin
                        state          <= S_INIT;
                        bus.busy       <= 1'b1;
                        bus.loop_init  <= 1'b1;
                        bus.loop_index <= '0;
                        for (int i = 0; i < MAX_LOOPS; i++) begin
                            cnt[i] <= '0;
                        end
                    end
                end
            end else if (!bus.stall) begin
                case (state)
                    S_INIT: begin
                        state          <= S_ENTER;
                        bus.loop_enter <= 1'b1;
                        bus.loop_index <= '0;
                    end
                    S_ENTER: begin
                        if (bus.loop_index == last) begin
                            state                <= S_INNER;
                            bus.loop_index_valid <= 1'b1;
                        end else begin
                            bus.loop_enter <= 1'b1;
                            bus.loop_index <= bus.loop_index + LOOP_ID_W'(1);
                        end
                    end
                    // cnt[last] holds the index of the iteration currently being presented.
                    S_INNER: begin
                        if (cnt[last] == iter_buf[last]) begin
                            state         <= S_EXIT;
                            bus.loop_exit <= 1'b1;
                            cnt[last]     <= '0;
                        end else begin
                            cnt[last]            <= cnt[last] + LOOP_ITER_W'(1);
                            bus.loop_index_valid <= 1'b1;
                        end
                    end
                    S_EXIT: begin
                        if (bus.loop_index == '0) begin
                            state              <= S_DONE;
                            bus.loop_ctrl_done <= 1'b1;
                            num_loops          <= '0;
                        end else if (cnt[level_up] < iter_buf[level_up]) begin
                            state                <= S_STEP;
                            bus.loop_index_valid <= 1'b1;
                            bus.loop_index       <= level_up;
                            cnt[level_up]        <= cnt[level_up] + LOOP_ITER_W'(1);
                        end else begin
                            bus.loop_exit  <= 1'b1;
                            bus.loop_index <= level_up;
                            cnt[level_up]  <= '0;
                        end
                    end
                    S_STEP: begin
                        state          <= S_ENTER;
                        bus.loop_enter <= 1'b1;
                        bus.loop_index <= bus.loop_index + LOOP_ID_W'(1);
                    end
                    S_DONE: begin
                        state          <= S_IDLE;
                        bus.busy       <= 1'b0;
                        bus.loop_index <= '0;
                    end
                    default: begin
                        state    <= S_IDLE;
                        bus.busy <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_loop_ctrl_nested_walker_drv.sv
// Directed bench for the nested-loop controller: event streams for several nests, stall,
// reset abort, ignored traffic while busy, and the full 32-level nest.
module tb_loop_ctrl_nested_walker_drv;
    localparam int ID_W = 5;
    localparam int IT_W = 16;

    localparam logic [4:0] F_NONE = 5'b00000;
    localparam logic [4:0] F_INIT = 5'b10000;
    localparam logic [4:0] F_EN   = 5'b01000;
    localparam logic [4:0] F_V    = 5'b00100;
    localparam logic [4:0] F_EX   = 5'b00010;
    localparam logic [4:0] F_DN   = 5'b00001;

    typedef logic [9:0] ev_t;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    ev_t  seq1[$];
    ev_t  seq_single[$];
    ev_t  seq_full[$];

    always #5 clk = ~clk;

    loop_ctrl_nested_walker_drv_if #(.LOOP_ID_W(ID_W), .LOOP_ITER_W(IT_W)) bus ();

    loop_ctrl_nested_walker_drv #(.LOOP_ID_W(ID_W), .LOOP_ITER_W(IT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic ev_t ev(input logic [4:0] f, input int l);
        return {f, 5'(l)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_output(input string tag, input logic [4:0] exp_flags,
                                input logic [4:0] exp_idx, input bit chk_idx, input logic exp_busy);
        check_val({tag, " flags"}, {27'b0, bus.loop_init, bus.loop_enter, bus.loop_index_valid,
                                    bus.loop_exit, bus.loop_ctrl_done}, {27'b0, exp_flags});
        if (chk_idx) check_val({tag, " index"}, {27'b0, bus.loop_index}, {27'b0, exp_idx});
        check_val({tag, " busy"}, {31'b0, bus.busy}, {31'b0, exp_busy});
    endtask

    task automatic apply_stimulus(input logic [IT_W-1:0] iter);
        bus.cfg_loop_iter_v = 1'b1;
        bus.cfg_loop_iter   = iter;
        tick();
        bus.cfg_loop_iter_v = 1'b0;
    endtask

    task automatic start_run();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Walks an expected event stream one cycle per entry, optionally stalling after one entry,
    // stopping early, or spraying cfg/start traffic that must be ignored while busy.
    task automatic run_check(input string tag, input ev_t seq[$], input int stall_at,
                             input int stall_len, input int stop_at, input bit noise);
        for (int i = 0; i < seq.size(); i++) begin
            ev_t e = seq[i];
            check_output($sformatf("%s ev%0d", tag, i), e[9:5], e[4:0], e[9:5] != F_DN, 1'b1);
            if (i == stop_at) return;
            if (noise) begin
                bus.cfg_loop_iter_v = (i < seq.size() - 1);
                bus.start           = (i < seq.size() - 1);
                bus.cfg_loop_iter   = 16'd7;
            end
            if (i == stall_at) begin
                bus.stall = 1'b1;
                for (int s = 0; s < stall_len; s++) begin
                    tick();
                    check_output($sformatf("%s stall%0d", tag, s), F_NONE, e[4:0], 1'b1, 1'b1);
                end
                bus.stall = 1'b0;
            end
            tick();
        end
        check_output({tag, " idle"}, F_NONE, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
        reset               = 1'b1;
        bus.cfg_loop_iter_v = 1'b0;
        bus.cfg_loop_iter   = '0;
        bus.start           = 1'b0;
        bus.stall           = 1'b0;

        seq1 = {ev(F_INIT, 0), ev(F_EN, 0), ev(F_EN, 1), ev(F_V, 1), ev(F_V, 1), ev(F_V, 1),
                ev(F_EX, 1), ev(F_V, 0), ev(F_EN, 1), ev(F_V, 1), ev(F_V, 1), ev(F_V, 1),
                ev(F_EX, 1), ev(F_EX, 0), ev(F_DN, 0)};
        seq_single = {ev(F_INIT, 0), ev(F_EN, 0), ev(F_V, 0), ev(F_EX, 0), ev(F_DN, 0)};
        seq_full.push_back(ev(F_INIT, 0));
        for (int l = 0; l < 32; l++) seq_full.push_back(ev(F_EN, l));
        seq_full.push_back(ev(F_V, 31));
        for (int l = 31; l >= 0; l--) seq_full.push_back(ev(F_EX, l));
        seq_full.push_back(ev(F_DN, 0));

        repeat (2) tick();
        check_output("reset", F_NONE, 5'd0, 1'b1, 1'b0);
        reset = 1'b0;
        tick();

        $display("[TB] two-level nest {1,2}");
        apply_stimulus(16'd1);
        apply_stimulus(16'd2);
        start_run();
        run_check("nest12", seq1, -1, 0, -1, 1'b0);

        $display("[TB] two-level nest with 3-cycle stall on second inner step");
        apply_stimulus(16'd1);
        apply_stimulus(16'd2);
        start_run();
        run_check("stall", seq1, 4, 3, -1, 1'b0);

        $display("[TB] single loop");
        apply_stimulus(16'd0);
        start_run();
        run_check("single", seq_single, -1, 0, -1, 1'b0);

        $display("[TB] start with empty config");
        start_run();
        check_output("empty done", F_DN, 5'd0, 1'b0, 1'b0);
        tick();
        check_output("empty after", F_NONE, 5'd0, 1'b0, 1'b0);

        $display("[TB] reset mid-run");
        apply_stimulus(16'd1);
        apply_stimulus(16'd2);
        start_run();
        run_check("abort", seq1, -1, 0, 4, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_output("abort reset", F_NONE, 5'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output($sformatf("abort quiet%0d", i), F_NONE, 5'd0, 1'b0, 1'b0);
        end
        apply_stimulus(16'd1);
        apply_stimulus(16'd2);
        start_run();
        run_check("rerun", seq1, -1, 0, -1, 1'b0);

        $display("[TB] cfg write and start in the same cycle");
        apply_stimulus(16'd1);
        bus.cfg_loop_iter_v = 1'b1;
        bus.cfg_loop_iter   = 16'd2;
        bus.start           = 1'b1;
        tick();
        bus.cfg_loop_iter_v = 1'b0;
        bus.start           = 1'b0;
        run_check("samecyc", seq1, -1, 0, -1, 1'b0);

        $display("[TB] cfg and start while busy are ignored");
        apply_stimulus(16'd0);
        start_run();
        run_check("noise", seq_single, -1, 0, -1, 1'b1);
        bus.cfg_loop_iter_v = 1'b0;
        bus.start           = 1'b0;
        start_run();
        check_output("noise empty", F_DN, 5'd0, 1'b0, 1'b0);
        tick();

        $display("[TB] 33 writes, 32-level nest");
        for (int i = 0; i < 32; i++) apply_stimulus(16'd0);
        apply_stimulus(16'd3);
        start_run();
        run_check("full", seq_full, -1, 0, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
